// File: rtl/cmd_pkg.sv
// cmd_pkg: shared definitions for the UART command dispatcher.
//   - opcode constants for ping / read / write
//   - dispatcher FSM state encoding
//   - response codes returned on the response handshake
//   - small helpers for opcode classification and response widening
package cmd_pkg;

  // Command opcodes (ASCII 'p', 'r', 'w')
  localparam logic [7:0] CMD_PING  = 8'h70;
  localparam logic [7:0] CMD_READ  = 8'h72;
  localparam logic [7:0] CMD_WRITE = 8'h77;

  // Response codes
  localparam logic [7:0]  RESP_ACK = 8'h06;
  localparam logic [7:0]  RESP_NAK = 8'h15;
  localparam logic [63:0] RESP_TMO = 64'hFFFF_FFFF_FFFF_FFFF;

  // Dispatcher states
  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_DECODE = 2'd1,
    S_BUS    = 2'd2,
    S_RESP   = 2'd3
  } state_t;

  // True for opcodes that need a bus transaction
  function automatic logic is_bus_cmd(input logic [7:0] op);
    return (op == CMD_READ) || (op == CMD_WRITE);
  endfunction

  // Widen an 8-bit response code to the 64-bit response word
  function automatic logic [63:0] resp_code(input logic [7:0] code);
    return {56'h0, code};
  endfunction

endpackage

// File: rtl/cmd_bus_timer.sv
// cmd_bus_timer: clear/enable cycle counter with an expire flag, used to
// bound how long a bus master waits for an acknowledge.
//   clk      in   1      clock
//   rst_n    in   1      synchronous reset, active-low
//   clr      in   1      force count to zero (has priority over en)
//   en       in   1      increment count by one
//   expired  out  1      count has reached TIMEOUT_CYC-1
module cmd_bus_timer #(
  parameter int TIMEOUT_CYC = 256
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam int CNT_W = $clog2(TIMEOUT_CYC);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT_CYC - 1);

  logic [CNT_W-1:0] count;

  // Cycle counter: clear wins over enable, otherwise hold
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (en) begin
      count <= count + CNT_W'(1);
    end else begin
      count <= count;
    end
  end

  assign expired = (count == LAST);

endmodule

// File: rtl/cmd_dispatch.sv
// cmd_dispatch: executes commands from the UART command controller on a
// simple single-outstanding register bus and returns a 64-bit response.
//   i_clk         in   1       clock
//   i_rst         in   1       synchronous reset, active-low
//   i_cmd         in   8       opcode (ping / read / write)
//   i_cmd_data    in   64      payload: {addr, wdata} in the low ADDR_W+DATA_W bits
//   i_cmd_new     in   1       command strobe level; rising edge starts a command
//   o_resp_ready  out  1       response valid, held until next accepted command
//   o_resp_data   out  64      response value
//   o_bus_req     out  1       bus request, held until ack or timeout
//   o_bus_we      out  1       1 = write, 0 = read
//   o_bus_addr    out  ADDR_W  bus address
//   o_bus_wdata   out  DATA_W  bus write data
//   i_bus_ack     in   1       single-cycle completion from target
//   i_bus_rdata   in   DATA_W  read data, valid with i_bus_ack
//   o_busy        out  1       high whenever the FSM is not idle
//   o_timeout     out  1       one-cycle pulse when a bus access is aborted
//   o_overrun     out  1       sticky: a command edge arrived while busy
module cmd_dispatch
  import cmd_pkg::*;
#(
  parameter int          ADDR_W      = 8,
  parameter int          DATA_W      = 32,
  parameter int          TIMEOUT_CYC = 256,
  parameter logic [63:0] PING_ID     = 64'h0000_0000_0000_00A5
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic [7:0]        i_cmd,
  input  logic [63:0]       i_cmd_data,
  input  logic              i_cmd_new,
  output logic              o_resp_ready,
  output logic [63:0]       o_resp_data,
  output logic              o_bus_req,
  output logic              o_bus_we,
  output logic [ADDR_W-1:0] o_bus_addr,
  output logic [DATA_W-1:0] o_bus_wdata,
  input  logic              i_bus_ack,
  input  logic [DATA_W-1:0] i_bus_rdata,
  output logic              o_busy,
  output logic              o_timeout,
  output logic              o_overrun
);

  localparam int PAY_W = ADDR_W + DATA_W;

  state_t           state;
  logic             new_prev;
  logic             cmd_edge;
  logic [7:0]       cmd_op;
  logic [PAY_W-1:0] cmd_payload;
  logic             timer_clr;
  logic             timer_en;
  logic             timer_expired;
  logic             unused_payload;

  // Payload bits above the address field carry nothing for this bus
  assign unused_payload = ^i_cmd_data;

  assign cmd_edge  = i_cmd_new & ~new_prev;
  // Timer restarts while decoding so it counts from zero on entry to S_BUS
  assign timer_clr = (state == S_DECODE);
  assign timer_en  = (state == S_BUS);

  cmd_bus_timer #(
    .TIMEOUT_CYC(TIMEOUT_CYC)
  ) u_timer (
    .clk     (i_clk),
    .rst_n   (i_rst),
    .clr     (timer_clr),
    .en      (timer_en),
    .expired (timer_expired)
  );

  // Dispatcher FSM with all outputs registered
  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      state        <= S_IDLE;
      new_prev     <= 1'b0;
      cmd_op       <= 8'h00;
      cmd_payload  <= '0;
      o_resp_ready <= 1'b0;
      o_resp_data  <= 64'h0;
      o_bus_req    <= 1'b0;
      o_bus_we     <= 1'b0;
      o_bus_addr   <= '0;
      o_bus_wdata  <= '0;
      o_busy       <= 1'b0;
      o_timeout    <= 1'b0;
      o_overrun    <= 1'b0;
    end else begin
      new_prev  <= i_cmd_new;
      o_timeout <= 1'b0;

      // Any edge outside S_IDLE is dropped, including the cycle of S_RESP
      if (cmd_edge && (state != S_IDLE)) begin
        o_overrun <= 1'b1;
      end

      case (state)
        S_IDLE: begin
          if (cmd_edge) begin
            cmd_op       <= i_cmd;
            cmd_payload  <= i_cmd_data[PAY_W-1:0];
            o_resp_ready <= 1'b0;
            o_resp_data  <= 64'h0;
            o_busy       <= 1'b1;
            state        <= S_DECODE;
          end
        end

        S_DECODE: begin
          if (cmd_op == CMD_PING) begin
            o_resp_data <= PING_ID;
            state       <= S_RESP;
          end else if (is_bus_cmd(cmd_op)) begin
            o_bus_addr  <= cmd_payload[PAY_W-1:DATA_W];
            o_bus_wdata <= cmd_payload[DATA_W-1:0];
            o_bus_we    <= (cmd_op == CMD_WRITE);
            o_bus_req   <= 1'b1;
            state       <= S_BUS;
          end else begin
            o_resp_data <= resp_code(RESP_NAK);
            state       <= S_RESP;
          end
        end

        S_BUS: begin
          // Ack is checked first so an ack in the expiry cycle still completes
          if (i_bus_ack) begin
            o_bus_req <= 1'b0;
            if (o_bus_we) begin
              o_resp_data <= resp_code(RESP_ACK);
            end else begin
              o_resp_data <= 64'(i_bus_rdata);
            end
            state <= S_RESP;
          end else if (timer_expired) begin
            o_bus_req   <= 1'b0;
            o_resp_data <= RESP_TMO;
            o_timeout   <= 1'b1;
            state       <= S_RESP;
          end
        end

        S_RESP: begin
          o_resp_ready <= 1'b1;
          o_busy       <= 1'b0;
          state        <= S_IDLE;
        end

        default: begin
          o_bus_req <= 1'b0;
          o_busy    <= 1'b0;
          state     <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cmd_dispatch.sv
// tb_cmd_dispatch: directed and randomized checks of cmd_dispatch against a
// behavioural response model.
module tb_cmd_dispatch;

  localparam int ADDR_W = 8;
  localparam int DATA_W = 32;
  localparam int TMO    = 16;

  logic              i_clk = 1'b0;
  logic              i_rst = 1'b0;
  logic [7:0]        i_cmd = 8'h00;
  logic [63:0]       i_cmd_data = 64'h0;
  logic              i_cmd_new = 1'b0;
  logic              o_resp_ready;
  logic [63:0]       o_resp_data;
  logic              o_bus_req;
  logic              o_bus_we;
  logic [ADDR_W-1:0] o_bus_addr;
  logic [DATA_W-1:0] o_bus_wdata;
  logic              i_bus_ack = 1'b0;
  logic [DATA_W-1:0] i_bus_rdata = '0;
  logic              o_busy;
  logic              o_timeout;
  logic              o_overrun;

  int checks = 0;
  int errors = 0;

  cmd_dispatch #(
    .ADDR_W      (ADDR_W),
    .DATA_W      (DATA_W),
    .TIMEOUT_CYC (TMO),
    .PING_ID     (64'h0000_0000_0000_00A5)
  ) dut (
    .i_clk        (i_clk),
    .i_rst        (i_rst),
    .i_cmd        (i_cmd),
    .i_cmd_data   (i_cmd_data),
    .i_cmd_new    (i_cmd_new),
    .o_resp_ready (o_resp_ready),
    .o_resp_data  (o_resp_data),
    .o_bus_req    (o_bus_req),
    .o_bus_we     (o_bus_we),
    .o_bus_addr   (o_bus_addr),
    .o_bus_wdata  (o_bus_wdata),
    .i_bus_ack    (i_bus_ack),
    .i_bus_rdata  (i_bus_rdata),
    .o_busy       (o_busy),
    .o_timeout    (o_timeout),
    .o_overrun    (o_overrun)
  );

  always #5 i_clk = ~i_clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge i_clk);
    #1;
  endtask

  // Response the command should produce; ack_at is the bus cycle the target
  // acknowledges in (anything beyond the timeout window means never).
  function automatic logic [63:0] model_resp(input logic [7:0] op,
                                             input logic [31:0] rdata,
                                             input int ack_at);
    case (op)
      8'h70:   return 64'hA5;
      8'h72:   return (ack_at <= TMO) ? {32'h0, rdata} : 64'hFFFF_FFFF_FFFF_FFFF;
      8'h77:   return (ack_at <= TMO) ? 64'h06 : 64'hFFFF_FFFF_FFFF_FFFF;
      default: return 64'h15;
    endcase
  endfunction

  // Present a command edge and check it was accepted
  task automatic start_cmd(input logic [7:0] op, input logic [63:0] data);
    i_cmd      = op;
    i_cmd_data = data;
    i_cmd_new  = 1'b1;
    step();
    i_cmd_new  = 1'b0;
    check("accept_busy", 64'(o_busy), 64'h1);
    check("accept_ready_clr", 64'(o_resp_ready), 64'h0);
    check("accept_data_clr", o_resp_data, 64'h0);
  endtask

  // Ping or unknown opcode: response two edges after the command edge
  task automatic run_simple(input logic [7:0] op);
    start_cmd(op, {$urandom, $urandom});
    step();
    check("simple_ready_early", 64'(o_resp_ready), 64'h0);
    check("simple_no_req1", 64'(o_bus_req), 64'h0);
    step();
    check("simple_ready", 64'(o_resp_ready), 64'h1);
    check("simple_data", o_resp_data, model_resp(op, 32'h0, 0));
    check("simple_no_req2", 64'(o_bus_req), 64'h0);
    check("simple_idle", 64'(o_busy), 64'h0);
  endtask

  // Bus command with target acking in cycle ack_at after the request rises;
  // glitch_at raises cmd_new during that bus cycle to provoke an overrun.
  task automatic run_bus(input logic [7:0] op, input logic [7:0] addr,
                         input logic [31:0] wdata, input logic [31:0] rdata,
                         input int ack_at, input int glitch_at);
    int end_at;
    int pulses;
    logic [63:0] exp;
    exp    = model_resp(op, rdata, ack_at);
    end_at = (ack_at >= 1 && ack_at <= TMO) ? ack_at : TMO;
    pulses = 0;
    start_cmd(op, {24'h0, addr, wdata});
    step();
    check("bus_req_rise", 64'(o_bus_req), 64'h1);
    check("bus_we", 64'(o_bus_we), 64'(op == 8'h77));
    check("bus_addr", 64'(o_bus_addr), 64'(addr));
    check("bus_wdata", 64'(o_bus_wdata), 64'(wdata));
    for (int k = 1; k <= end_at; k++) begin
      i_bus_ack   = (k == ack_at);
      i_bus_rdata = (k == ack_at) ? rdata : $urandom;
      i_cmd_new   = (k == glitch_at);
      step();
      i_bus_ack = 1'b0;
      i_cmd_new = 1'b0;
      if (o_timeout) pulses++;
      if (k < end_at) begin
        check("bus_req_held", 64'(o_bus_req), 64'h1);
        check("bus_addr_stable", 64'(o_bus_addr), 64'(addr));
        check("bus_wdata_stable", 64'(o_bus_wdata), 64'(wdata));
      end
    end
    check("bus_req_drop", 64'(o_bus_req), 64'h0);
    check("bus_tmo_pulses", 64'(pulses), 64'(ack_at > TMO));
    check("bus_ready_early", 64'(o_resp_ready), 64'h0);
    step();
    check("bus_tmo_cleared", 64'(o_timeout), 64'h0);
    check("bus_ready", 64'(o_resp_ready), 64'h1);
    check("bus_resp", o_resp_data, exp);
    check("bus_idle", 64'(o_busy), 64'h0);
  endtask

  initial begin
    logic [7:0] op;
    logic [63:0] held;

    // Reset
    repeat (3) step();
    check("rst_ready", 64'(o_resp_ready), 64'h0);
    check("rst_data", o_resp_data, 64'h0);
    check("rst_req", 64'(o_bus_req), 64'h0);
    check("rst_busy", 64'(o_busy), 64'h0);
    check("rst_flags", {62'h0, o_timeout, o_overrun}, 64'h0);
    i_rst = 1'b1;
    step();

    // Directed cases
    run_simple(8'h70);
    run_bus(8'h77, 8'h12, 32'hCAFEBABE, 32'h0, 3, 0);
    run_bus(8'h72, 8'h34, 32'h0, 32'h11223344, 2, 0);
    run_bus(8'h72, 8'h56, 32'h0, 32'hDEAD0001, 99, 0);
    run_bus(8'h77, 8'h78, 32'h01234567, 32'h0, TMO, 0);
    run_simple(8'h41);
    check("no_overrun_yet", 64'(o_overrun), 64'h0);

    // Randomized commands
    for (int n = 0; n < 14; n++) begin
      case ($urandom_range(0, 3))
        0: run_simple(8'h70);
        1: run_bus(8'h72, 8'($urandom), $urandom, $urandom, $urandom_range(1, 20), 0);
        2: run_bus(8'h77, 8'($urandom), $urandom, $urandom, $urandom_range(1, 20), 0);
        default: begin
          op = 8'($urandom);
          if (op == 8'h70 || op == 8'h72 || op == 8'h77) op = 8'h00;
          run_simple(op);
        end
      endcase
    end
    check("no_overrun_random", 64'(o_overrun), 64'h0);

    // Ack while idle is ignored
    held = o_resp_data;
    i_bus_ack   = 1'b1;
    i_bus_rdata = 32'h5A5A5A5A;
    step();
    i_bus_ack = 1'b0;
    step();
    check("idle_ack_data", o_resp_data, held);
    check("idle_ack_busy", 64'(o_busy), 64'h0);
    check("idle_ack_ready", 64'(o_resp_ready), 64'h1);

    // Second edge during S_BUS is dropped and sets overrun
    run_bus(8'h72, 8'h9A, 32'h0, 32'h0BADF00D, 5, 2);
    check("overrun_set", 64'(o_overrun), 64'h1);

    // Reset in the middle of a bus transaction
    start_cmd(8'h77, {24'h0, 8'hAB, 32'h87654321});
    step();
    check("mid_req_up", 64'(o_bus_req), 64'h1);
    step();
    i_rst = 1'b0;
    step();
    check("mid_rst_req", 64'(o_bus_req), 64'h0);
    check("mid_rst_ready", 64'(o_resp_ready), 64'h0);
    check("mid_rst_busy", 64'(o_busy), 64'h0);
    check("mid_rst_overrun", 64'(o_overrun), 64'h0);
    i_rst = 1'b1;
    step();

    // Edge in the cycle the FSM returns to idle is dropped
    start_cmd(8'h70, 64'h0);
    step();
    i_cmd_new = 1'b1;
    step();
    check("ret_edge_ready", 64'(o_resp_ready), 64'h1);
    check("ret_edge_overrun", 64'(o_overrun), 64'h1);
    check("ret_edge_busy", 64'(o_busy), 64'h0);
    step();
    check("ret_edge_stays_idle", 64'(o_busy), 64'h0);
    check("ret_edge_resp_held", o_resp_data, 64'hA5);
    i_cmd_new = 1'b0;
    step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
